// File: rtl/snake_body_pkg.sv
// Shared encodings and constants for the snake body tracker.
package snake_body_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    GS_READY = 2'b00,
    GS_PLAY  = 2'b01,
    GS_PAUSE = 2'b10,
    GS_OVER  = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } snake_state_e;

  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 24;

  localparam logic [4:0] START_X = 5'd16;
  localparam logic [4:0] START_Y = 5'd12;

  // Opposite headings differ only in bit 1 of the encoding.
  function automatic logic is_reversal(input dir_e cur, input dir_e req);
    return req == dir_e'(cur ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_body_if.sv
// Game-control, food, display-scan and status signals of the snake body.
interface snake_body_if;
  // No valid/ready pair: move_tick is a one-cycle strobe that is always
  // accepted; the body acts on it only while running with game_state==play.
  logic [1:0] game_state;
  logic       move_tick;
  logic [1:0] dir_in;
  logic [4:0] food_x;
  logic [4:0] food_y;
  logic [4:0] qry_x;
  logic [4:0] qry_y;
  logic       qry_hit;
  logic       qry_head;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [4:0] length;
  logic       get_food;
  logic       dead;
  logic [1:0] state_dbg;

  modport slave (
    input  game_state, move_tick, dir_in, food_x, food_y, qry_x, qry_y,
    output qry_hit, qry_head, head_x, head_y, length, get_food, dead, state_dbg
  );

  modport master (
    output game_state, move_tick, dir_in, food_x, food_y, qry_x, qry_y,
    input  qry_hit, qry_head, head_x, head_y, length, get_food, dead, state_dbg
  );
endinterface

// File: rtl/snake_next_head.sv
// Next head cell, wall flag and reversal filter; 6-bit math so that
// stepping off either edge shows up as an out-of-range coordinate.
module snake_next_head
  import snake_body_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic [4:0] head_x,
  input  logic [4:0] head_y,
  input  dir_e       cur_dir,
  input  dir_e       req_dir,
  output dir_e       new_dir,
  output logic [5:0] nxt_x,
  output logic [5:0] nxt_y,
  output logic       wall
);

  always_comb begin
    new_dir = is_reversal(cur_dir, req_dir) ? cur_dir : req_dir;
    nxt_x   = {1'b0, head_x};
    nxt_y   = {1'b0, head_y};
    case (new_dir)
      DIR_UP:    nxt_y = {1'b0, head_y} - 6'd1;
      DIR_RIGHT: nxt_x = {1'b0, head_x} + 6'd1;
      DIR_DOWN:  nxt_y = {1'b0, head_y} + 6'd1;
      default:   nxt_x = {1'b0, head_x} - 6'd1;
    endcase
    // Underflow wraps to 63, so one unsigned compare covers both edges.
    wall = (nxt_x >= 6'(GRID_W)) || (nxt_y >= 6'(GRID_H));
  end

endmodule

// File: rtl/snake_body.sv
// Snake segment buffer: steps the body on move ticks, detects wall and
// self collisions, grows on food, and answers display-scan queries.
module snake_body
  import snake_body_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input logic         clk,
  input logic         rst,
  snake_body_if.slave bus
);

  localparam logic [4:0] MAX_LEN_L  = 5'(MAX_LEN);
  localparam logic [4:0] INIT_LEN_L = 5'(INIT_LEN);

  snake_state_e state_q, state_d;
  dir_e         dir_q, dir_d;
  logic [4:0]   seg_x_q [MAX_LEN];
  logic [4:0]   seg_x_d [MAX_LEN];
  logic [4:0]   seg_y_q [MAX_LEN];
  logic [4:0]   seg_y_d [MAX_LEN];
  logic [4:0]   length_q, length_d;
  logic         get_food_q, get_food_d;
  logic         dead_q, dead_d;

  dir_e       new_dir;
  logic [5:0] nxt_x, nxt_y;
  logic       wall;
  logic       step, food_match, grow, self_hit, collide;
  logic       qry_hit, qry_head;

  snake_next_head #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next_head (
    .head_x  (seg_x_q[0]),
    .head_y  (seg_y_q[0]),
    .cur_dir (dir_q),
    .req_dir (dir_e'(bus.dir_in)),
    .new_dir (new_dir),
    .nxt_x   (nxt_x),
    .nxt_y   (nxt_y),
    .wall    (wall)
  );

  always_comb begin
    step       = (state_q == ST_RUN) && (bus.game_state == GS_PLAY) && bus.move_tick;
    food_match = (nxt_x == {1'b0, bus.food_x}) && (nxt_y == {1'b0, bus.food_y});
    grow       = food_match && (length_q < MAX_LEN_L);
    // The tail vacates its cell this step unless the body is growing.
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((5'(i) < length_q) && ((5'(i) != length_q - 5'd1) || grow) &&
          ({1'b0, seg_x_q[i]} == nxt_x) && ({1'b0, seg_y_q[i]} == nxt_y))
        self_hit = 1'b1;
    end
    collide = wall || self_hit;
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    seg_x_d    = seg_x_q;
    seg_y_d    = seg_y_q;
    length_d   = length_q;
    get_food_d = 1'b0;
    dead_d     = dead_q;

    case (state_q)
      ST_INIT: if (bus.game_state == GS_PLAY) state_d = ST_RUN;
      ST_RUN:  if (step && collide) state_d = ST_DEAD;
      default: state_d = ST_DEAD;
    endcase

    if (step) begin
      dir_d = new_dir;
      if (collide) begin
        dead_d = 1'b1;
      end else begin
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x_d[i] = seg_x_q[i-1];
          seg_y_d[i] = seg_y_q[i-1];
        end
        seg_x_d[0] = nxt_x[4:0];
        seg_y_d[0] = nxt_y[4:0];
        if (food_match) begin
          get_food_d = 1'b1;
          if (grow) length_d = length_q + 5'd1;
        end
      end
    end

    // Reset and re-arm share the same load; this overrides any step.
    if (rst || (bus.game_state == GS_READY)) begin
      state_d    = ST_INIT;
      dir_d      = DIR_RIGHT;
      length_d   = INIT_LEN_L;
      get_food_d = 1'b0;
      dead_d     = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = START_X - 5'(i);
        seg_y_d[i] = START_Y;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    dir_q      <= dir_d;
    seg_x_q    <= seg_x_d;
    seg_y_q    <= seg_y_d;
    length_q   <= length_d;
    get_food_q <= get_food_d;
    dead_q     <= dead_d;
  end

  always_comb begin
    qry_hit  = 1'b0;
    qry_head = (seg_x_q[0] == bus.qry_x) && (seg_y_q[0] == bus.qry_y);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < length_q) && (seg_x_q[i] == bus.qry_x) && (seg_y_q[i] == bus.qry_y))
        qry_hit = 1'b1;
    end
  end

  assign bus.qry_hit   = qry_hit;
  assign bus.qry_head  = qry_head;
  assign bus.head_x    = seg_x_q[0];
  assign bus.head_y    = seg_y_q[0];
  assign bus.length    = length_q;
  assign bus.get_food  = get_food_q;
  assign bus.dead      = dead_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: movement, eating, walls, self collision,
// pause and re-arm, with hand-computed expected cells.
module tb_snake_body;
  import snake_body_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  snake_body_if bus ();

  snake_body dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic [1:0] d);
    @(negedge clk);
    bus.dir_in    = d;
    bus.move_tick = 1'b1;
    @(negedge clk);
    bus.move_tick = 1'b0;
  endtask

  task automatic start_play();
    @(negedge clk);
    bus.game_state = GS_READY;
    @(negedge clk);
    bus.game_state = GS_PLAY;
  endtask

  task automatic set_food(input logic [4:0] x, input logic [4:0] y);
    bus.food_x = x;
    bus.food_y = y;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.game_state = GS_PLAY;
    bus.move_tick  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.move_tick  = 1'b0;
    bus.game_state = GS_READY;
    @(negedge clk);
    n_checks++;
    if ({bus.head_x, bus.head_y} !== {5'd16, 5'd12}) begin
      n_fail++; $display("FAIL reset_head: got (%0d,%0d) expected (16,12)", bus.head_x, bus.head_y);
    end
    n_checks++;
    if ({bus.length, bus.dead, bus.get_food, bus.state_dbg} !== {5'd3, 1'b0, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL reset_status: got len=%0d dead=%b food=%b st=%0d expected 3/0/0/0",
                         bus.length, bus.dead, bus.get_food, bus.state_dbg);
    end
    bus.qry_x = 5'd14; bus.qry_y = 5'd12; #1;
    n_checks++;
    if ({bus.qry_hit, bus.qry_head} !== 2'b10) begin
      n_fail++; $display("FAIL reset_qry_tail: got hit=%b head=%b expected 1/0", bus.qry_hit, bus.qry_head);
    end
    bus.qry_x = 5'd16; #1;
    n_checks++;
    if ({bus.qry_hit, bus.qry_head} !== 2'b11) begin
      n_fail++; $display("FAIL reset_qry_head: got hit=%b head=%b expected 1/1", bus.qry_hit, bus.qry_head);
    end
  endtask

  task automatic test_init_ignore();
    bus.game_state = GS_OVER;
    tick(DIR_DOWN);
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.state_dbg, bus.get_food} !== {5'd16, 5'd12, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL init_tick_ignored: got (%0d,%0d) st=%0d food=%b expected (16,12) st=0 food=0",
                         bus.head_x, bus.head_y, bus.state_dbg, bus.get_food);
    end
  endtask

  task automatic test_run_right();
    start_play();
    repeat (3) tick(DIR_RIGHT);
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.length, bus.get_food} !== {5'd19, 5'd12, 5'd3, 1'b0}) begin
      n_fail++; $display("FAIL run_right: got (%0d,%0d) len=%0d food=%b expected (19,12) len=3 food=0",
                         bus.head_x, bus.head_y, bus.length, bus.get_food);
    end
    n_checks++;
    if (bus.state_dbg !== 2'd1) begin
      n_fail++; $display("FAIL run_state: got %0d expected 1", bus.state_dbg);
    end
    bus.qry_x = 5'd16; bus.qry_y = 5'd12; #1;
    n_checks++;
    if (bus.qry_hit !== 1'b0) begin
      n_fail++; $display("FAIL run_stale_qry: got hit=%b expected 0", bus.qry_hit);
    end
    bus.qry_x = 5'd17; #1;
    n_checks++;
    if ({bus.qry_hit, bus.qry_head} !== 2'b10) begin
      n_fail++; $display("FAIL run_tail_qry: got hit=%b head=%b expected 1/0", bus.qry_hit, bus.qry_head);
    end
  endtask

  task automatic test_reset_mid_step();
    @(negedge clk);
    rst = 1'b1;
    bus.dir_in    = DIR_RIGHT;
    bus.move_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.move_tick = 1'b0;
    bus.game_state = GS_READY;
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.state_dbg} !== {5'd16, 5'd12, 2'd0}) begin
      n_fail++; $display("FAIL reset_mid_step: got (%0d,%0d) st=%0d expected (16,12) st=0",
                         bus.head_x, bus.head_y, bus.state_dbg);
    end
  endtask

  task automatic test_eat();
    start_play();
    set_food(5'd17, 5'd12);
    tick(DIR_RIGHT);
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.length, bus.get_food} !== {5'd17, 5'd12, 5'd4, 1'b1}) begin
      n_fail++; $display("FAIL eat: got (%0d,%0d) len=%0d food=%b expected (17,12) len=4 food=1",
                         bus.head_x, bus.head_y, bus.length, bus.get_food);
    end
    set_food(5'd0, 5'd0);
    @(negedge clk);
    n_checks++;
    if (bus.get_food !== 1'b0) begin
      n_fail++; $display("FAIL eat_pulse_width: got food=%b expected 0", bus.get_food);
    end
  endtask

  task automatic test_reversal();
    tick(DIR_LEFT);
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.length} !== {5'd18, 5'd12, 5'd4}) begin
      n_fail++; $display("FAIL reversal: got (%0d,%0d) len=%0d expected (18,12) len=4",
                         bus.head_x, bus.head_y, bus.length);
    end
  endtask

  task automatic test_pause_rearm();
    bus.game_state = GS_PAUSE;
    tick(DIR_UP);
    tick(DIR_UP);
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.length, bus.state_dbg} !== {5'd18, 5'd12, 5'd4, 2'd1}) begin
      n_fail++; $display("FAIL pause: got (%0d,%0d) len=%0d st=%0d expected (18,12) len=4 st=1",
                         bus.head_x, bus.head_y, bus.length, bus.state_dbg);
    end
    bus.game_state = GS_READY;
    @(negedge clk);
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.length, bus.state_dbg} !== {5'd16, 5'd12, 5'd3, 2'd0}) begin
      n_fail++; $display("FAIL rearm: got (%0d,%0d) len=%0d st=%0d expected (16,12) len=3 st=0",
                         bus.head_x, bus.head_y, bus.length, bus.state_dbg);
    end
    bus.qry_x = 5'd14; bus.qry_y = 5'd12; #1;
    n_checks++;
    if (bus.qry_hit !== 1'b1) begin
      n_fail++; $display("FAIL rearm_qry_14: got hit=%b expected 1", bus.qry_hit);
    end
    bus.qry_x = 5'd13; #1;
    n_checks++;
    if (bus.qry_hit !== 1'b0) begin
      n_fail++; $display("FAIL rearm_qry_13: got hit=%b expected 0", bus.qry_hit);
    end
  endtask

  task automatic test_wall();
    start_play();
    repeat (7) tick(DIR_UP);
    repeat (15) tick(DIR_RIGHT);
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.dead} !== {5'd31, 5'd5, 1'b0}) begin
      n_fail++; $display("FAIL wall_approach: got (%0d,%0d) dead=%b expected (31,5) dead=0",
                         bus.head_x, bus.head_y, bus.dead);
    end
    tick(DIR_RIGHT);
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.dead, bus.state_dbg, bus.length} !== {5'd31, 5'd5, 1'b1, 2'd2, 5'd3}) begin
      n_fail++; $display("FAIL wall_hit: got (%0d,%0d) dead=%b st=%0d len=%0d expected (31,5) dead=1 st=2 len=3",
                         bus.head_x, bus.head_y, bus.dead, bus.state_dbg, bus.length);
    end
    set_food(5'd31, 5'd4);
    tick(DIR_UP);
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.dead, bus.get_food, bus.state_dbg} !== {5'd31, 5'd5, 1'b1, 1'b0, 2'd2}) begin
      n_fail++; $display("FAIL dead_tick_ignored: got (%0d,%0d) dead=%b food=%b st=%0d expected (31,5) 1/0/2",
                         bus.head_x, bus.head_y, bus.dead, bus.get_food, bus.state_dbg);
    end
    set_food(5'd0, 5'd0);
  endtask

  task automatic test_self_body();
    start_play();
    set_food(5'd17, 5'd12);
    tick(DIR_RIGHT);
    set_food(5'd18, 5'd12);
    tick(DIR_RIGHT);
    set_food(5'd0, 5'd0);
    n_checks++;
    if (bus.length !== 5'd5) begin
      n_fail++; $display("FAIL grow_to_5: got len=%0d expected 5", bus.length);
    end
    tick(DIR_UP);
    tick(DIR_LEFT);
    tick(DIR_DOWN);
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.dead, bus.length, bus.state_dbg} !== {5'd17, 5'd11, 1'b1, 5'd5, 2'd2}) begin
      n_fail++; $display("FAIL self_hit: got (%0d,%0d) dead=%b len=%0d st=%0d expected (17,11) dead=1 len=5 st=2",
                         bus.head_x, bus.head_y, bus.dead, bus.length, bus.state_dbg);
    end
    bus.qry_x = 5'd16; bus.qry_y = 5'd12; #1;
    n_checks++;
    if (bus.qry_hit !== 1'b1) begin
      n_fail++; $display("FAIL self_hit_body_kept: got hit=%b expected 1", bus.qry_hit);
    end
  endtask

  task automatic test_self_tail();
    start_play();
    set_food(5'd17, 5'd12);
    tick(DIR_RIGHT);
    set_food(5'd0, 5'd0);
    tick(DIR_UP);
    tick(DIR_LEFT);
    tick(DIR_DOWN);
    n_checks++;
    if ({bus.head_x, bus.head_y, bus.dead, bus.length, bus.state_dbg} !== {5'd16, 5'd12, 1'b0, 5'd4, 2'd1}) begin
      n_fail++; $display("FAIL tail_chase: got (%0d,%0d) dead=%b len=%0d st=%0d expected (16,12) dead=0 len=4 st=1",
                         bus.head_x, bus.head_y, bus.dead, bus.length, bus.state_dbg);
    end
    bus.qry_x = 5'd17; bus.qry_y = 5'd12; #1;
    n_checks++;
    if ({bus.qry_hit, bus.qry_head} !== 2'b10) begin
      n_fail++; $display("FAIL tail_chase_qry: got hit=%b head=%b expected 1/0", bus.qry_hit, bus.qry_head);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.game_state = GS_READY;
    bus.move_tick  = 1'b0;
    bus.dir_in     = DIR_RIGHT;
    bus.food_x     = 5'd0;
    bus.food_y     = 5'd0;
    bus.qry_x      = 5'd0;
    bus.qry_y      = 5'd0;

    test_reset();
    test_init_ignore();
    test_run_right();
    test_reset_mid_step();
    test_eat();
    test_reversal();
    test_pause_rearm();
    test_wall();
    test_self_body();
    test_self_tail();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
